key_conditioner: RTL and testbench

Conditions the two raw push-button inputs before they reach the segment-display controller. Both keys are synchronised and debounced, then turned into clean levels plus single-cycle press, release and long-press events, so the display logic can step pages and modes without seeing contact bounce. Runs on the fast board clock, not the divided CPU clock, and sits between the board pins and the display controller's `key` input.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_channel.sv | 126 ++++++++++++
 rtl/key_conditioner.sv | 35 +++
 tb/tb_key_conditioner.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types for the push-button conditioner: channel FSM states and pulse slots.
// Optional auto-repeat is enabled with KEY_AUTOREPEAT_EN.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        LONG_HELD,
        REL_WAIT_H,
        REL_WAIT_L
    } key_state_t;

    // Bit positions inside a channel's registered event vector.
    localparam int PULSE_PRESS   = 0;
    localparam int PULSE_RELEASE = 1;
    localparam int PULSE_LONG    = 2;
    localparam int PULSE_W       = 3;

endpackage

// File: rtl/key_channel.sv
// One key: polarity fix, 2-flop synchroniser, debounce/hold FSM and event pulses.
// KEY_AUTOREPEAT_EN adds periodic press pulses while a long hold continues.
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned LONG_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic released,
    output logic long_hold
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES);
    localparam int HCW = $clog2(LONG_CYCLES + 1);

    // Compared against the pre-increment value, so the transition lands on
    // the edge where the count reaches its target.
    localparam logic [DCW-1:0] D_FIRE = DCW'(DEBOUNCE_CYCLES - 2);
    localparam logic [HCW-1:0] L_FIRE = HCW'(LONG_CYCLES - 1);

    logic             sync1;
    logic             p;
    key_state_t       state;
    logic [DCW-1:0]   dcnt;
    logic [HCW-1:0]   hcnt;
    logic [HCW-1:0]   hcnt_inc;
    logic [PULSE_W-1:0] pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            p     <= 1'b0;
        end else begin
            sync1 <= ACTIVE_LOW ? ~raw : raw;
            p     <= sync1;
        end
    end

    assign hcnt_inc = (hcnt == '1) ? hcnt : hcnt + HCW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= '0;
            hcnt  <= '0;
            level <= 1'b0;
            pulse <= '0;
        end else begin
            pulse <= '0;
            case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == D_FIRE) begin
                        state              <= HELD;
                        dcnt               <= '0;
                        hcnt               <= '0;
                        level              <= 1'b1;
                        pulse[PULSE_PRESS] <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                HELD: begin
                    if (!p) begin
                        state <= REL_WAIT_H;
                        dcnt  <= '0;
                    end else if (hcnt == L_FIRE) begin
                        state             <= LONG_HELD;
                        hcnt              <= '0;
                        pulse[PULSE_LONG] <= 1'b1;
                    end else begin
                        hcnt <= hcnt_inc;
                    end
                end
                LONG_HELD: begin
                    if (!p) begin
                        state <= REL_WAIT_L;
                        dcnt  <= '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (hcnt == HCW'(REPEAT_CYCLES - 1)) begin
                        hcnt               <= '0;
                        pulse[PULSE_PRESS] <= 1'b1;
                    end else begin
                        hcnt <= hcnt_inc;
                    end
`endif
                end
                REL_WAIT_H, REL_WAIT_L: begin
                    // A bounce back to pressed resumes the frozen hold/repeat count.
                    if (p) begin
                        state <= (state == REL_WAIT_H) ? HELD : LONG_HELD;
                    end else if (dcnt == D_FIRE) begin
                        state                <= IDLE;
                        dcnt                 <= '0;
                        level                <= 1'b0;
                        pulse[PULSE_RELEASE] <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign press     = pulse[PULSE_PRESS];
    assign released  = pulse[PULSE_RELEASE];
    assign long_hold = pulse[PULSE_LONG];

endmodule

// File: rtl/key_conditioner.sv
// Two independent debounced key channels feeding the display controller.
// Define KEY_AUTOREPEAT_EN to get auto-repeat press pulses during long holds.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned LONG_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_raw,
    output logic [1:0] key_level,
    output logic [1:0] key_press,
    output logic [1:0] key_release,
    output logic [1:0] key_long
);

    for (genvar i = 0; i < 2; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw       (key_raw[i]),
            .level     (key_level[i]),
            .press     (key_press[i]),
            .released  (key_release[i]),
            .long_hold (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key
// activity, all compared cycle by cycle against a run-length reference model.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_raw = 2'b11;
    logic [1:0] key_level, key_press, key_release, key_long;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    // Reference model: tracks runs of identical synchronised samples per key.
    bit   m_s1 [2];
    bit   m_p [2];
    bit   m_level [2];
    bit   m_longd [2];
    int   m_prun [2];
    int   m_rrun [2];
    int   m_hold [2];
    int   m_rep [2];
    logic [1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;

    task automatic model_edge();
        e_press = '0; e_release = '0; e_long = '0;
        for (int k = 0; k < 2; k++) begin
            bit pv;
            if (rst) begin
                m_s1[k] = 0; m_p[k] = 0; m_level[k] = 0; m_longd[k] = 0;
                m_prun[k] = 0; m_rrun[k] = 0; m_hold[k] = 0; m_rep[k] = 0;
            end else begin
                pv = m_p[k];
                m_p[k] = m_s1[k];
                m_s1[k] = ~key_raw[k];
                if (!m_level[k]) begin
                    m_prun[k] = pv ? m_prun[k] + 1 : 0;
                    if (m_prun[k] == D) begin
                        m_level[k] = 1; e_press[k] = 1'b1;
                        m_prun[k] = 0; m_rrun[k] = 0; m_hold[k] = 0; m_longd[k] = 0;
                    end
                end else if (!pv) begin
                    m_rrun[k]++;
                    if (m_rrun[k] == D) begin
                        m_level[k] = 0; e_release[k] = 1'b1; m_rrun[k] = 0;
                    end
                end else begin
                    // Time only accrues on pressed samples with no release pending.
                    if (m_rrun[k] == 0) begin
                        if (!m_longd[k]) begin
                            m_hold[k]++;
                            if (m_hold[k] == L) begin
                                e_long[k] = 1'b1; m_longd[k] = 1; m_rep[k] = 0;
                            end
                        end
`ifdef KEY_AUTOREPEAT_EN
                        else begin
                            m_rep[k]++;
                            if (m_rep[k] == R) begin
                                e_press[k] = 1'b1; m_rep[k] = 0;
                            end
                        end
`endif
                    end
                    m_rrun[k] = 0;
                end
            end
            e_level[k] = m_level[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        int first;
        rst = 1'b1; key_raw = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=0", cyc, {key_level, key_press, key_release, key_long});
            end
        end
        rst = 1'b0;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
            if (first < 0 && key_press == 2'b11) first = i;
        end
        checks++;
        if (first != 6) begin
            errors++;
            $display("FAIL reset_first_press got=%0d want=6", first);
        end
        key_raw = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
        end
    endtask

    task automatic test_clean_press();
        int at, rels;
        at = -1; rels = 0;
        key_raw[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL clean_press cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
            if (key_press[0]) at = (at < 0) ? i : 99;
        end
        checks++;
        if (at != 6 || key_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_press_latency got=%0d level=%b want=6 level=1", at, key_level[0]);
        end
        key_raw[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL clean_release cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
            if (key_release[0]) rels++;
        end
        checks++;
        if (rels != 1 || key_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_count got=%0d level=%b want=1 level=0", rels, key_level[0]);
        end
    endtask

    task automatic test_bounce();
        int events, presses;
        events = 0; presses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                key_raw[1] = (i == 3);
                tick();
                checks++;
                if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                    errors++;
                    $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
                end
                if (key_press[1] || key_release[1] || key_long[1] || key_level[1]) events++;
            end
        end
        checks++;
        if (events != 0) begin
            errors++;
            $display("FAIL bounce_quiet got=%0d events want=0", events);
        end
        key_raw[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL bounce_hold cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
            if (key_press[1]) presses++;
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL bounce_single_press got=%0d want=1", presses);
        end
        key_raw[1] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
    endtask

    // Presses key 0 and waits for its press pulse; glitch_at > 0 opens a 2-cycle release then.
    task automatic test_long_repeat(input int glitch_at);
        int seen, long_off, want_long, long_cnt, rep_cnt, rep_sum, rels;
        seen = 0; long_off = -1; want_long = -1; long_cnt = 0; rep_cnt = 0; rep_sum = 0; rels = 0;
        key_raw[0] = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (key_press[0]) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL long_wait_press no press within 20 cycles");
        end
        for (int j = 1; j <= 40; j++) begin
            if (glitch_at > 0) key_raw[0] = (j == glitch_at || j == glitch_at + 1);
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL long_hold cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
            if (key_long[0]) begin long_cnt++; long_off = j; end
            if (e_long[0]) want_long = j;
            if (key_press[0]) begin rep_cnt++; rep_sum += j; end
            if (key_release[0]) rels++;
        end
        checks++;
        if (long_cnt != 1 || rels != 0) begin
            errors++;
            $display("FAIL long_count got long=%0d rel=%0d want long=1 rel=0", long_cnt, rels);
        end
        checks++;
        if (glitch_at == 0 && long_off != 20) begin
            errors++;
            $display("FAIL long_offset got=%0d want=20", long_off);
        end else if (glitch_at > 0 && (long_off != want_long || long_off <= 20)) begin
            errors++;
            $display("FAIL glitch_long_offset got=%0d want=%0d", long_off, want_long);
        end
        if (glitch_at == 0) begin
            checks++;
`ifdef KEY_AUTOREPEAT_EN
            if (rep_cnt != 4 || rep_sum != 130) begin
                errors++;
                $display("FAIL repeat got count=%0d sum=%0d want count=4 sum=130", rep_cnt, rep_sum);
            end
`else
            if (rep_cnt != 0) begin
                errors++;
                $display("FAIL no_repeat got=%0d want=0", rep_cnt);
            end
`endif
        end
        key_raw[0] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_mid_hold();
        int at, rels;
        at = -1; rels = 0;
        key_raw[0] = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (key_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL midhold_level got=%b want=1", key_level[0]);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
                errors++;
                $display("FAIL midhold_reset cyc=%0d got=%b want=0", cyc, {key_level, key_press, key_release, key_long});
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL midhold_repress cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
            if (key_press[0] && at < 0) at = i;
            if (key_release[0]) rels++;
        end
        checks++;
        if (at != 6 || rels != 0) begin
            errors++;
            $display("FAIL midhold_after got press_at=%0d rel=%0d want 6 and 0", at, rels);
        end
        key_raw[0] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_simultaneous();
        logic [1:0] first_p, first_r;
        first_p = 2'b00; first_r = 2'b00;
        key_raw = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (first_p == 2'b00) first_p = key_press;
        end
        checks++;
        if (first_p !== 2'b11) begin
            errors++;
            $display("FAIL simul_press got=%b want=11", first_p);
        end
        key_raw = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (first_r == 2'b00) first_r = key_release;
        end
        checks++;
        if (first_r !== 2'b11) begin
            errors++;
            $display("FAIL simul_release got=%b want=11", first_r);
        end
    endtask

    task automatic test_random();
        int seg [2];
        seg[0] = 0; seg[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (seg[k] == 0) begin
                    key_raw[k] = 1'($urandom_range(0, 1));
                    seg[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
                end
                seg[k]--;
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {e_level, e_press, e_release, e_long}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, {key_level, key_press, key_release, key_long}, {e_level, e_press, e_release, e_long});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat(0);
        test_long_repeat(10);
        test_reset_mid_hold();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
